// File: rtl/uart_rx_pkg.sv
// Shared types and frame geometry for the UART receive path.
package uart_rx_pkg;

  localparam int DATA_BITS  = 7;
  localparam int FRAME_BITS = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Host-side valid/ready handshake carrying the received byte and its error flags.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic                 rx_valid;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 parity_error;
  logic                 framing_error;
  logic                 overrun_error;

  modport master (
    output rx_valid, rx_data, parity_error, framing_error, overrun_error,
    input  rx_ready
  );

  modport slave (
    input  rx_valid, rx_data, parity_error, framing_error, overrun_error,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_bit_timer.sv
// Bit-period counter with mid-bit strobe; UART_RX_MAJORITY_VOTE_EN adds mid-1/mid+1 strobes.
module uart_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
`ifdef UART_RX_MAJORITY_VOTE_EN
  output logic mid_m1_stb,
  output logic mid_p1_stb,
`endif
  output logic mid_stb
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;

  logic [CW-1:0] cnt;

  // The cycle that raises restart is itself bit time 0, so the counter lands on 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (restart)
      cnt <= CW'(1);
    else if (cnt == CW'(CLKS_PER_BIT - 1))
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign mid_stb = (cnt == CW'(MID));

`ifdef UART_RX_MAJORITY_VOTE_EN
  assign mid_m1_stb = (cnt == CW'(MID - 1));
  assign mid_p1_stb = (cnt == CW'(MID + 1));
`endif

endmodule

// File: rtl/uart_rx_controller.sv
// UART receiver: 7 data bits LSB-first, odd parity, 1 stop, valid/ready host handshake.
// Build option UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around mid-bit instead of a single sample.
module uart_rx_controller
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        busy,
  uart_rx_if.master   host
);

  logic                  rx_meta;
  logic                  rxs;
  state_t                state;
  logic [2:0]            bit_idx;
  logic                  done;
  logic [FRAME_BITS-1:0] frame;
  logic                  restart;
  logic                  mid_stb;
  logic                  bit_stb;
  logic                  bit_val;
  logic                  parity_ok;
  logic                  stop_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign restart = (state == IDLE) && !rxs;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic mid_m1_stb;
  logic mid_p1_stb;
  logic vote_a;
  logic vote_b;

  uart_rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart),
    .mid_m1_stb (mid_m1_stb),
    .mid_p1_stb (mid_p1_stb),
    .mid_stb    (mid_stb)
  );

  always_ff @(posedge clk) begin
    if (mid_m1_stb) vote_a <= rxs;
    if (mid_stb)    vote_b <= rxs;
  end

  // Third vote is the live sample at mid+1; the FSM registers the decision there.
  assign bit_stb = mid_p1_stb;
  assign bit_val = maj3(vote_a, vote_b, rxs);
`else
  uart_rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .mid_stb (mid_stb)
  );

  assign bit_stb = mid_stb;
  assign bit_val = rxs;
`endif

  always_ff @(posedge clk) begin
    if (bit_stb) begin
      case (state)
        DATA:    frame[bit_idx]        <= bit_val;
        PARITY:  frame[DATA_BITS]      <= bit_val;
        STOP:    frame[FRAME_BITS - 1] <= bit_val;
        default: ;
      endcase
    end
  end

  // Errors are evaluated on the captured frame, valid on the cycle done is high.
  assign parity_ok = ^frame[DATA_BITS:0];
  assign stop_bad  = !frame[FRAME_BITS - 1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      bit_idx            <= '0;
      done               <= 1'b0;
      busy               <= 1'b0;
      host.rx_valid      <= 1'b0;
      host.rx_data       <= '0;
      host.parity_error  <= 1'b0;
      host.framing_error <= 1'b0;
      host.overrun_error <= 1'b0;
    end else begin
      done               <= 1'b0;
      host.overrun_error <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_stb) begin
            if (bit_val) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
        end
        DATA: begin
          if (bit_stb) begin
            if (bit_idx == 3'(DATA_BITS - 1))
              state <= PARITY;
            else
              bit_idx <= bit_idx + 3'd1;
          end
        end
        PARITY: begin
          if (bit_stb) state <= STOP;
        end
        STOP: begin
          if (bit_stb) begin
            done <= 1'b1;
            if (bit_val) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= BREAK_WAIT;
            end
          end
        end
        BREAK_WAIT: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A completion may reload the output in the same cycle the host takes the old one.
      if (done && (!host.rx_valid || host.rx_ready)) begin
        host.rx_valid      <= 1'b1;
        host.rx_data       <= frame[DATA_BITS-1:0];
        host.parity_error  <= !parity_ok;
        host.framing_error <= stop_bad;
      end else if (done) begin
        host.overrun_error <= 1'b1;
      end else if (host.rx_valid && host.rx_ready) begin
        host.rx_valid <= 1'b0;
      end
    end
  end

endmodule
